// File: rtl/xb_sample_port.sv
// Sample read/write responder for the wavelet engine: input sample FIFO feeding a
// one-shot read grant handshake, output FIFO capturing write strobes, frame-length quit.
module xb_sample_port #(
  parameter int unsigned DW        = 16,
  parameter int unsigned IN_DEPTH  = 16,
  parameter int unsigned OUT_DEPTH = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_valid,
  input  logic [DW-1:0]    src_data,
  output logic             src_ready,
  input  logic             read_req,
  output logic             read_ready,
  output logic [DW-1:0]    read_data,
  input  logic             write_req,
  input  logic [DW-1:0]    write_data,
  output logic             dst_valid,
  output logic [DW-1:0]    dst_data,
  input  logic             dst_ready,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             frame_clr,
  output logic             read_quit,
  output logic [CNT_W-1:0] served_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic             wr_ovf
);

  localparam int unsigned IAW = $clog2(IN_DEPTH);
  localparam int unsigned OAW = $clog2(OUT_DEPTH);
  localparam logic [IAW:0] IN_FULL  = (IAW+1)'(IN_DEPTH);
  localparam logic [OAW:0] OUT_FULL = (OAW+1)'(OUT_DEPTH);

  typedef enum logic {R_IDLE, R_ACK} rstate_t;

  rstate_t state, state_nxt;

  logic [DW-1:0]  in_mem [IN_DEPTH];
  logic [IAW-1:0] in_wr_ptr, in_rd_ptr;
  logic [IAW:0]   in_count;
  logic           push_in, grant;

  logic [DW-1:0]  out_mem [OUT_DEPTH];
  logic [OAW-1:0] out_wr_ptr, out_rd_ptr;
  logic [OAW:0]   out_count;
  logic           push_out, pop_out, drop_out;

  // Gated by reset so the reset cycle itself never advertises space.
  assign src_ready = ~reset & (in_count != IN_FULL);
  assign push_in   = src_valid & src_ready;

  assign dst_valid = (out_count != '0);
  assign dst_data  = out_mem[out_rd_ptr];
  assign pop_out   = dst_valid & dst_ready;
  assign push_out  = write_req & ((out_count != OUT_FULL) | pop_out);
  assign drop_out  = write_req & ~push_out;

  // Read FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= R_IDLE;
    else       state <= state_nxt;
  end

  // Read FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE:  if (grant)     state_nxt = R_ACK;
      R_ACK:   if (!read_req) state_nxt = R_IDLE;
      default:                state_nxt = R_IDLE;
    endcase
  end

  // Read FSM: outputs (grant pops the FIFO and drives the registered handshake)
  always_comb begin
    grant = 1'b0;
    if (state == R_IDLE)
      grant = read_req & ~read_quit & (in_count != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_ready <= 1'b0;
      read_data  <= '0;
    end else begin
      read_ready <= grant;
      if (grant) read_data <= in_mem[in_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push_in) in_mem[in_wr_ptr] <= src_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      in_count  <= '0;
    end else begin
      if (push_in) in_wr_ptr <= in_wr_ptr + IAW'(1);
      if (grant)   in_rd_ptr <= in_rd_ptr + IAW'(1);
      case ({push_in, grant})
        2'b10:   in_count <= in_count + (IAW+1)'(1);
        2'b01:   in_count <= in_count - (IAW+1)'(1);
        default: in_count <= in_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_out) out_mem[out_wr_ptr] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_count  <= '0;
    end else begin
      if (push_out) out_wr_ptr <= out_wr_ptr + OAW'(1);
      if (pop_out)  out_rd_ptr <= out_rd_ptr + OAW'(1);
      case ({push_out, pop_out})
        2'b10:   out_count <= out_count + (OAW+1)'(1);
        2'b01:   out_count <= out_count - (OAW+1)'(1);
        default: out_count <= out_count;
      endcase
    end
  end

  // frame_clr zeroes the counters but a same-cycle grant/write still counts as one.
  always_ff @(posedge clk) begin
    if (reset) begin
      served_cnt <= '0;
      wr_cnt     <= '0;
      wr_ovf     <= 1'b0;
      read_quit  <= 1'b0;
    end else begin
      if (frame_clr)
        served_cnt <= grant ? CNT_W'(1) : '0;
      else if (grant && served_cnt != '1)
        served_cnt <= served_cnt + CNT_W'(1);

      if (frame_clr)
        wr_cnt <= push_out ? CNT_W'(1) : '0;
      else if (push_out && wr_cnt != '1)
        wr_cnt <= wr_cnt + CNT_W'(1);

      if (frame_clr) wr_ovf <= drop_out;
      else           wr_ovf <= wr_ovf | drop_out;

      read_quit <= (frame_len != '0) & (served_cnt == frame_len);
    end
  end

endmodule
